transpose_window_buffer: RTL and testbench

TRANSPOSE_WINDOW_BUFFER -- requirements
Module: transpose_window_buffer

---
 rtl/transpose_window_buffer.sv | 62 ++++++
 tb/tb_transpose_window_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/transpose_window_buffer.sv
// transpose_window_buffer: sliding ROWS-deep row window presented column-major, with valid/ready on both sides.
module transpose_window_buffer #(
    parameter int PIX_W = 8,
    parameter int COLS  = 8,
    parameter int ROWS  = 15,
    parameter int CW    = 5
) (
    input  logic                        clock,
    input  logic                        reset_L,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [COLS*PIX_W-1:0]       in_row,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ROWS*COLS*PIX_W-1:0]  out_win,
    output logic [CW-1:0]               fill_cnt
);
    typedef enum logic [1:0] {FILL, PEND, DONE} state_t;
    state_t state, state_nxt;
    logic [COLS*PIX_W-1:0] row [ROWS];
    logic accept, consume;
    always_comb begin
        in_ready  = !clear && !(state == PEND && !out_ready);
        out_valid = !clear && state == PEND;
        accept    = in_valid && in_ready;
        consume   = out_valid && out_ready;
        state_nxt = state;
        if (clear)
            state_nxt = FILL;
        else
            unique case (state)
                FILL:    state_nxt = (accept && fill_cnt == CW'(ROWS - 1)) ? PEND : FILL;
                PEND:    state_nxt = (consume && !accept) ? DONE : PEND;
                DONE:    state_nxt = accept ? PEND : DONE;
                default: state_nxt = FILL;
            endcase
    end
    always_ff @(posedge clock or negedge reset_L)
        if (!reset_L)
            state <= FILL;
        else
            state <= state_nxt;
    always_ff @(posedge clock or negedge reset_L)
        if (!reset_L) begin
            fill_cnt <= '0;
            for (int i = 0; i < ROWS; i++) row[i] <= '0;
        end else if (clear) begin
            fill_cnt <= '0;
            for (int i = 0; i < ROWS; i++) row[i] <= '0;
        end else if (accept) begin
            if (fill_cnt != CW'(ROWS)) fill_cnt <= fill_cnt + 1'b1;
            for (int i = 0; i < ROWS - 1; i++) row[i] <= row[i+1];
            row[ROWS-1] <= in_row;
        end
    // column-major: all ROWS samples of pixel column c sit next to each other
    for (genvar c = 0; c < COLS; c++) begin : g_c
        for (genvar r = 0; r < ROWS; r++) begin : g_r
            assign out_win[(c*ROWS+r)*PIX_W +: PIX_W] = row[r][c*PIX_W +: PIX_W];
        end
    end
endmodule

// File: tb/tb_transpose_window_buffer.sv
// tb_transpose_window_buffer: queue-based window model checked every cycle, plus directed literal checks.
module tb_transpose_window_buffer;
    localparam int P = 8, C = 8, R = 15;
    logic clock = 0, reset_L = 1, clear = 0, in_valid = 0, out_ready = 0;
    logic [C*P-1:0] in_row = '0;
    logic in_ready, out_valid;
    logic [R*C*P-1:0] out_win;
    logic [4:0] fill_cnt;
    logic s_in_valid = 0, s_out_ready = 0, s_clear = 0;
    logic [39:0] s_in_row = '0;
    logic s_in_ready, s_out_valid;
    logic [239:0] s_out_win;
    logic [2:0] s_fill_cnt;
    int checks = 0, errors = 0, rst_cnt = 0, seen_rst = 0;
    logic [C*P-1:0] q[$];
    logic pend = 0;
    int n, nbad, bad_c, bad_r;
    logic [P-1:0] e, bad_a, bad_e;
    logic [C*P-1:0] rw;
    logic exp_valid, exp_ready, acc, cons;

    transpose_window_buffer dut (
        .clock(clock), .reset_L(reset_L), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win), .fill_cnt(fill_cnt));
    transpose_window_buffer #(.PIX_W(10), .COLS(4), .ROWS(6), .CW(3)) dut_s (
        .clock(clock), .reset_L(reset_L), .clear(s_clear), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_row(s_in_row), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_win(s_out_win),
        .fill_cnt(s_fill_cnt));

    initial forever #5 clock = ~clock;
    initial forever begin
        @(negedge reset_L);
        rst_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [P-1:0] pix(input int c, input int r);
        return out_win[(c*R+r)*P +: P];
    endfunction

    function automatic logic [C*P-1:0] mk(input int k);
        logic [C*P-1:0] v;
        for (int c = 0; c < C; c++) v[c*P +: P] = P'(16*k + c);
        return v;
    endfunction

    task automatic push(input logic [C*P-1:0] v);
        in_valid = 1;
        in_row = v;
        @(posedge clock); #1;
        in_valid = 0;
    endtask

    // model: queue of the last R accepted rows, oldest first, plus a "fresh window" flag
    initial forever begin
        @(negedge clock);
        if (rst_cnt != seen_rst || !reset_L) begin
            q.delete();
            pend = 0;
            seen_rst = rst_cnt;
        end
        exp_valid = pend && !clear;
        exp_ready = !clear && !(pend && !out_ready);
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        chk("fill_cnt", {27'b0, fill_cnt}, q.size());
        n = q.size();
        nbad = 0;
        bad_c = 0; bad_r = 0; bad_a = '0; bad_e = '0;
        for (int r = 0; r < R; r++) begin
            rw = (r >= R - n) ? q[r-(R-n)] : '0;
            for (int c = 0; c < C; c++) begin
                e = rw[c*P +: P];
                if (pix(c, r) !== e) begin
                    if (nbad == 0) begin bad_c = c; bad_r = r; bad_a = pix(c, r); bad_e = e; end
                    nbad++;
                end
            end
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL out_win: %0d pixels differ, first c=%0d r=%0d got %0h expected %0h",
                     nbad, bad_c, bad_r, bad_a, bad_e);
        end
        if (reset_L) begin
            acc = in_valid && exp_ready;
            cons = exp_valid && out_ready;
            if (clear) begin
                q.delete();
                pend = 0;
            end else begin
                if (acc) begin
                    q.push_back(in_row);
                    if (q.size() > R) void'(q.pop_front());
                end
                pend = (acc && q.size() == R) ? 1'b1 : (cons ? 1'b0 : pend);
            end
        end
    end

    initial begin
        #1 reset_L = 0;
        #2;
        chk("rst out_valid", {31'b0, out_valid}, 0);
        chk("rst in_ready", {31'b0, in_ready}, 1);
        chk("rst out_win", {31'b0, |out_win}, 0);
        #9 reset_L = 1;
        @(posedge clock); #1;
        // fill
        for (int k = 0; k < 14; k++) push(mk(k));
        chk("fill 14 out_valid", {31'b0, out_valid}, 0);
        push(mk(14));
        chk("fill out_valid", {31'b0, out_valid}, 1);
        chk("fill in_ready", {31'b0, in_ready}, 0);
        chk("fill fill_cnt", {27'b0, fill_cnt}, 15);
        chk("fill pix c3 r14", {24'b0, pix(3, 14)}, 32'hE3);
        // backpressure
        in_valid = 1;
        in_row = mk(15);
        repeat (5) begin @(posedge clock); #1; end
        chk("bp fill_cnt", {27'b0, fill_cnt}, 15);
        chk("bp out_valid", {31'b0, out_valid}, 1);
        chk("bp pix c0 r0", {24'b0, pix(0, 0)}, 32'h00);
        chk("bp pix c0 r14", {24'b0, pix(0, 14)}, 32'hE0);
        out_ready = 1;
        #1 chk("bp in_ready", {31'b0, in_ready}, 1);
        @(posedge clock); #1;
        in_valid = 0;
        out_ready = 0;
        chk("bp next out_valid", {31'b0, out_valid}, 1);
        chk("bp next pix c0 r14", {24'b0, pix(0, 14)}, 32'hF0);
        chk("bp next pix c0 r0", {24'b0, pix(0, 0)}, 32'h10);
        // consume only
        out_ready = 1;
        @(posedge clock); #1;
        out_ready = 0;
        chk("co out_valid", {31'b0, out_valid}, 0);
        chk("co fill_cnt", {27'b0, fill_cnt}, 15);
        chk("co in_ready", {31'b0, in_ready}, 1);
        push(mk(16));
        chk("co re out_valid", {31'b0, out_valid}, 1);
        chk("co pix c5 r14", {24'b0, pix(5, 14)}, 32'h05);
        chk("co pix c0 r0", {24'b0, pix(0, 0)}, 32'h20);
        // clear
        clear = 1;
        @(posedge clock); #1;
        clear = 0;
        chk("clr fill_cnt", {27'b0, fill_cnt}, 0);
        for (int k = 0; k < 9; k++) push(mk(k + 32));
        chk("clr fill 9", {27'b0, fill_cnt}, 9);
        clear = 1;
        in_valid = 1;
        in_row = mk(99);
        #1;
        chk("clr in_ready", {31'b0, in_ready}, 0);
        chk("clr out_valid", {31'b0, out_valid}, 0);
        @(posedge clock); #1;
        clear = 0;
        in_valid = 0;
        chk("clr2 fill_cnt", {27'b0, fill_cnt}, 0);
        chk("clr2 out_win", {31'b0, |out_win}, 0);
        for (int k = 0; k < 14; k++) push(mk(k + 48));
        chk("clr 14 out_valid", {31'b0, out_valid}, 0);
        push(mk(62));
        chk("clr 15 out_valid", {31'b0, out_valid}, 1);
        chk("clr 15 fill_cnt", {27'b0, fill_cnt}, 15);
        chk("clr pix c2 r14", {24'b0, pix(2, 14)}, 32'hE2);
        chk("clr pix c2 r0", {24'b0, pix(2, 0)}, 32'h02);
        // asynchronous reset between edges while a window is pending
        #1 reset_L = 0;
        #1;
        chk("arst out_valid", {31'b0, out_valid}, 0);
        chk("arst fill_cnt", {27'b0, fill_cnt}, 0);
        chk("arst out_win", {31'b0, |out_win}, 0);
        chk("arst in_ready", {31'b0, in_ready}, 1);
        #1 reset_L = 1;
        push(mk(1));
        chk("arst first accept", {27'b0, fill_cnt}, 1);
        chk("arst pix c0 r14", {24'b0, pix(0, 14)}, 32'h10);
        // small parameter set
        for (int k = 0; k < 6; k++) begin
            s_in_valid = 1;
            for (int c = 0; c < 4; c++) s_in_row[c*10 +: 10] = 10'(16*k + c);
            @(posedge clock); #1;
            s_in_valid = 0;
            if (k == 4) chk("small 5 out_valid", {31'b0, s_out_valid}, 0);
        end
        chk("small out_valid", {31'b0, s_out_valid}, 1);
        chk("small fill_cnt", {29'b0, s_fill_cnt}, 6);
        chk("small in_ready", {31'b0, s_in_ready}, 0);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 6; r++)
                chk($sformatf("small pix c%0d r%0d", c, r), {22'b0, s_out_win[(c*6+r)*10 +: 10]}, 16*r + c);
        @(posedge clock); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
